// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and constants for the SRAM slave and its interface.
// Response codes are restricted to the two this slave can produce.
package axi4l_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRESP,
        ST_RDATA
    } state_e;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle without prot fields; the slave modport is what the SRAM uses.
interface axi4l_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);

    logic                     awvalid;
    logic                     awready;
    logic [AddrWidth-1:0]     awaddr;
    logic                     wvalid;
    logic                     wready;
    logic [DataWidth-1:0]     wdata;
    logic [DataWidth/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    axi4l_pkg::resp_t         bresp;
    logic                     arvalid;
    logic                     arready;
    logic [AddrWidth-1:0]     araddr;
    logic                     rvalid;
    logic                     rready;
    logic [DataWidth-1:0]     rdata;
    axi4l_pkg::resp_t         rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4l_sram_mem.sv
// Single-port word RAM with byte enables and a registered read port.
// rdata only changes on a read request, so it holds while a response waits.
module axi4l_sram_mem
    import axi4l_pkg::*;
#(
    parameter int    Depth    = 16384,
    parameter string InitFile = ""
) (
    input  logic                       clk,
    input  logic                       req,
    input  logic                       we,
    input  logic [AXI_STRB_W-1:0]      be,
    input  logic [$clog2(Depth)-1:0]   addr,
    input  logic [AXI_DATA_W-1:0]      wdata,
    output logic [AXI_DATA_W-1:0]      rdata
);

    logic [AXI_DATA_W-1:0] mem_q [Depth];
    logic [AXI_DATA_W-1:0] rdata_q;

    // NOTE: storage and read register have no reset so this maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (req) begin
            if (we) begin
                for (int b = 0; b < AXI_STRB_W; b++) begin
                    if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4l_sram.sv
// AXI4-Lite slave over a word SRAM: one transaction in flight, round-robin
// read/write arbitration, SLVERR for accesses outside the address window.
module axi4l_sram
    import axi4l_pkg::*;
#(
    parameter int                   AddrWidth = 32,
    parameter int                   DataWidth = 32,
    parameter int                   Depth     = 16384,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter string                InitFile  = ""
) (
    input logic     clk,
    input logic     rst_n,
    axi4l_if.slave  axi
);

    localparam int                 IdxW     = $clog2(Depth);
    localparam int                 StrbW    = DataWidth / 8;
    localparam logic [AddrWidth:0] WinBytes = (AddrWidth+1)'(64'(Depth) * 64'd4);

    state_e                 state_q, state_d;
    logic                   live_q, live_d;
    logic                   aw_full_q, aw_full_d;
    logic [AddrWidth-1:0]   aw_addr_q, aw_addr_d;
    logic                   w_full_q, w_full_d;
    logic [DataWidth-1:0]   w_data_q, w_data_d;
    logic [StrbW-1:0]       w_strb_q, w_strb_d;
    logic                   prio_rd_q, prio_rd_d;
    logic                   bvalid_q, bvalid_d;
    resp_t                  bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    resp_t                  rresp_q, rresp_d;

    logic                   wr_pend, rd_pend, idle, grant_wr, grant_rd;
    logic                   aw_in_win, ar_in_win;
    logic [IdxW-1:0]        aw_idx, ar_idx;
    logic                   mem_req, mem_we;
    logic [IdxW-1:0]        mem_addr;
    logic [DataWidth-1:0]   mem_rdata;

    // Unsigned compare on the full address; below-base addresses fail the first term.
    function automatic logic in_window(input logic [AddrWidth-1:0] a);
        logic [AddrWidth:0] off;
        off = {1'b0, a} - {1'b0, BaseAddr};
        return (a >= BaseAddr) && (off < WinBytes);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] a);
        logic [AddrWidth-1:0] off;
        off = a - BaseAddr;
        return IdxW'(off >> 2);
    endfunction

    assign aw_in_win = in_window(aw_addr_q);
    assign ar_in_win = in_window(axi.araddr);
    assign aw_idx    = word_idx(aw_addr_q);
    assign ar_idx    = word_idx(axi.araddr);

    assign wr_pend   = aw_full_q && w_full_q;
    assign rd_pend   = axi.arvalid;
    assign idle      = live_q && (state_q == ST_IDLE);
    assign grant_rd  = idle && rd_pend && (!wr_pend || prio_rd_q);
    assign grant_wr  = idle && wr_pend && !grant_rd;

    assign axi.awready = live_q && !aw_full_q;
    assign axi.wready  = live_q && !w_full_q;
    assign axi.arready = grant_rd;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = (rvalid_q && rresp_q == OKAY) ? mem_rdata : '0;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        prio_rd_d = prio_rd_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ar_idx;

        if (axi.awvalid && axi.awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi.awaddr;
        end
        if (axi.wvalid && axi.wready) begin
            w_full_d = 1'b1;
            w_data_d = axi.wdata;
            w_strb_d = axi.wstrb;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    mem_req   = aw_in_win;
                    mem_we    = 1'b1;
                    mem_addr  = aw_idx;
                    bvalid_d  = 1'b1;
                    bresp_d   = aw_in_win ? OKAY : SLVERR;
                    prio_rd_d = 1'b1;
                    state_d   = ST_WRESP;
                end else if (grant_rd) begin
                    mem_req   = ar_in_win;
                    rvalid_d  = 1'b1;
                    rresp_d   = ar_in_win ? OKAY : SLVERR;
                    prio_rd_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_WRESP: begin
                if (axi.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (axi.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            live_q    <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            prio_rd_q <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            prio_rd_q <= prio_rd_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    axi4l_sram_mem #(
        .Depth    (Depth),
        .InitFile (InitFile)
    ) u_mem (
        .clk   (clk),
        .req   (mem_req),
        .we    (mem_we),
        .be    (w_strb_q),
        .addr  (mem_addr),
        .wdata (w_data_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi4l_sram.sv
// Bench for axi4l_sram: directed vector table, hand-written corner sequences,
// and a randomized phase scored against an in-order memory model.
module tb_axi4l_sram;
    import axi4l_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] TOPA  = BASE + 32'(4 * DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4l_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    axi4l_sram #(
        .AddrWidth (32),
        .DataWidth (32),
        .Depth     (DEPTH),
        .BaseAddr  (BASE),
        .InitFile  ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          hold;
        logic [31:0] exp_data;
        resp_t       exp_resp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint off;
        off = longint'({32'b0, a}) - longint'({32'b0, BASE});
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic vec_t mkw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input int h, input resp_t r);
        vec_t v;
        v = '{1'b1, a, d, s, h, 32'h0, r};
        return v;
    endfunction

    function automatic vec_t mkr(input logic [31:0] a, input logic [31:0] e, input int h,
                                 input resp_t r);
        vec_t v;
        v = '{1'b0, a, 32'h0, 4'h0, h, e, r};
        return v;
    endfunction

    task automatic idle_inputs();
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold,
                            input resp_t exp_resp, input string name);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0, lat = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.awaddr  = addr;
            bus.wvalid  = !w_done && (cyc >= w_dly);
            bus.wdata   = data;
            bus.wstrb   = strb;
            #1;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check({name, "_aw_w_accepted"}, 32'(aw_done && w_done), 32'd1);
        while (!bus.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_b_latency"}, 32'(lat), 32'd1);
        check({name, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, "_b_hold_valid"}, 32'(bus.bvalid), 32'd1);
            check({name, "_b_hold_resp"}, 32'(bus.bresp), 32'(exp_resp));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check({name, "_b_dropped"}, 32'(bus.bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input int hold,
                           input resp_t exp_resp, input string name);
        bit hs = 0, rdy;
        int cyc = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        while (!hs && cyc < 50) begin
            #1;
            rdy = bus.arready;
            tick();
            hs = rdy;
            cyc++;
        end
        bus.arvalid = 1'b0;
        check({name, "_ar_accepted"}, 32'(hs), 32'd1);
        check({name, "_r_latency"}, 32'(bus.rvalid), 32'd1);
        check({name, "_rdata"}, bus.rdata, exp_data);
        check({name, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, "_r_hold_valid"}, 32'(bus.rvalid), 32'd1);
            check({name, "_r_hold_data"}, bus.rdata, exp_data);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check({name, "_r_dropped"}, 32'(bus.rvalid), 32'd0);
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Arbitration with both sides always pending: expect R,W,R,W and frozen payloads.
    task automatic test_round_robin();
        int n;
        bit is_rd;
        apply_reset();
        bus.awvalid = 1'b1; bus.awaddr = BASE + 32'h40;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = BASE + 32'h10;
        for (int k = 0; k < 4; k++) begin
            is_rd = (k % 2) == 0;
            n = 0;
            while (!(bus.bvalid || bus.rvalid) && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("rr%0d_kind", k), {30'b0, bus.bvalid, bus.rvalid}, is_rd ? 32'd1 : 32'd2);
            for (int h = 0; h < 5; h++) begin
                tick();
                check($sformatf("rr%0d_no_grant", k), 32'(bus.arready), 32'd0);
                if (is_rd) begin
                    check($sformatf("rr%0d_rdata_stable", k), bus.rdata, 32'hDEAD_BEEF);
                    check($sformatf("rr%0d_rvalid_stable", k), {30'b0, bus.bvalid, bus.rvalid}, 32'd1);
                end else begin
                    check($sformatf("rr%0d_bresp_stable", k), 32'(bus.bresp), 32'(OKAY));
                    check($sformatf("rr%0d_bvalid_stable", k), {30'b0, bus.bvalid, bus.rvalid}, 32'd2);
                end
            end
            if (is_rd) bus.rready = 1'b1; else bus.bready = 1'b1;
            tick();
            bus.rready = 1'b0;
            bus.bready = 1'b0;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        bus.bready  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.bready  = 1'b0;
        check("rr_drained", {30'b0, bus.bvalid, bus.rvalid}, 32'd0);
        do_read(BASE + 32'h40, 32'h0BAD_F00D, 0, OKAY, "rr_written");
    endtask

    task automatic test_reset_mid_read();
        bus.arvalid = 1'b1;
        bus.araddr  = BASE + 32'h10;
        for (int i = 0; i < 10 && !bus.arready; i++) begin
            #1;
            if (!bus.arready) tick();
        end
        tick();
        bus.arvalid = 1'b0;
        check("rst_mid_rvalid_before", 32'(bus.rvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'h0);
        check("rst_mid_arready", 32'(bus.arready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_no_late_r", 32'(bus.rvalid), 32'd0);
        end
        do_read(BASE + 32'h10, 32'hDEAD_BEEF, 0, OKAY, "rst_mid_retained");
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] oob [4];
        oob[0] = TOPA; oob[1] = BASE - 32'd4; oob[2] = 32'hFFFF_FFFC; oob[3] = TOPA + 32'h100;
        if ($urandom_range(0, 7) == 0) return oob[$urandom_range(0, 3)];
        return BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
    endfunction

    task automatic run_random(input int n_ops);
        logic [31:0] aw_q[$], wd_q[$], ar_q[$];
        logic [3:0]  ws_q[$];
        int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, cyc = 0;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        resp_t b_resp, r_resp;
        logic [31:0] r_data, a, d, e;
        logic [3:0] s;
        idle_inputs();
        while ((b_n < n_ops || r_n < n_ops) && cyc < 4000) begin
            if (!bus.awvalid && aw_n < n_ops && $urandom_range(0, 2) == 0) begin
                bus.awaddr = rand_addr(); bus.awvalid = 1'b1;
            end
            if (!bus.wvalid && w_n < n_ops && $urandom_range(0, 2) == 0) begin
                bus.wdata = $urandom; bus.wstrb = 4'($urandom_range(0, 15)); bus.wvalid = 1'b1;
            end
            if (!bus.arvalid && ar_n < n_ops && $urandom_range(0, 2) == 0) begin
                bus.araddr = rand_addr(); bus.arvalid = 1'b1;
            end
            bus.bready = 1'($urandom_range(0, 1));
            bus.rready = 1'($urandom_range(0, 1));
            #1;
            aw_hs  = bus.awvalid && bus.awready;
            w_hs   = bus.wvalid && bus.wready;
            ar_hs  = bus.arvalid && bus.arready;
            b_hs   = bus.bvalid && bus.bready;
            r_hs   = bus.rvalid && bus.rready;
            b_resp = bus.bresp;
            r_resp = bus.rresp;
            r_data = bus.rdata;
            tick();
            cyc++;
            if (aw_hs) begin aw_q.push_back(bus.awaddr); aw_n++; bus.awvalid = 1'b0; end
            if (w_hs) begin wd_q.push_back(bus.wdata); ws_q.push_back(bus.wstrb); w_n++; bus.wvalid = 1'b0; end
            if (ar_hs) begin ar_q.push_back(bus.araddr); ar_n++; bus.arvalid = 1'b0; end
            if (b_hs) begin
                b_n++;
                check("rnd_b_has_request", 32'(aw_q.size() > 0 && wd_q.size() > 0), 32'd1);
                if (aw_q.size() > 0 && wd_q.size() > 0) begin
                    a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
                    check($sformatf("rnd_bresp@%h", a), 32'(b_resp), in_win(a) ? 32'(OKAY) : 32'(SLVERR));
                    if (in_win(a)) begin
                        e = model[widx(a)];
                        for (int b = 0; b < 4; b++) if (s[b]) e[8*b +: 8] = d[8*b +: 8];
                        model[widx(a)] = e;
                    end
                end
            end
            if (r_hs) begin
                r_n++;
                check("rnd_r_has_request", 32'(ar_q.size() > 0), 32'd1);
                if (ar_q.size() > 0) begin
                    a = ar_q.pop_front();
                    check($sformatf("rnd_rresp@%h", a), 32'(r_resp), in_win(a) ? 32'(OKAY) : 32'(SLVERR));
                    check($sformatf("rnd_rdata@%h", a), r_data, in_win(a) ? model[widx(a)] : 32'h0);
                end
            end
        end
        idle_inputs();
        check("rnd_all_b", 32'(b_n), 32'(n_ops));
        check("rnd_all_r", 32'(r_n), 32'(n_ops));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        vecs.push_back(mkw(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, OKAY));
        vecs.push_back(mkr(BASE + 32'h10, 32'hDEAD_BEEF, 0, OKAY));
        vecs.push_back(mkw(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, OKAY));
        vecs.push_back(mkw(BASE + 32'h20, 32'h1122_3344, 4'b0101, 2, OKAY));
        vecs.push_back(mkr(BASE + 32'h20, 32'hFF22_FF44, 3, OKAY));
        vecs.push_back(mkw(BASE, 32'hA5A5_A5A5, 4'hF, 0, OKAY));
        vecs.push_back(mkw(TOPA - 32'd4, 32'h5A5A_5A5A, 4'hF, 0, OKAY));
        vecs.push_back(mkw(TOPA, 32'h1234_5678, 4'hF, 1, SLVERR));
        vecs.push_back(mkw(BASE - 32'd4, 32'h8765_4321, 4'hF, 0, SLVERR));
        vecs.push_back(mkr(TOPA, 32'h0, 2, SLVERR));
        vecs.push_back(mkr(BASE - 32'd4, 32'h0, 0, SLVERR));
        vecs.push_back(mkr(BASE, 32'hA5A5_A5A5, 0, OKAY));
        vecs.push_back(mkr(TOPA - 32'd4, 32'h5A5A_5A5A, 0, OKAY));
        vecs.push_back(mkw(BASE + 32'h22, 32'hCAFE_F00D, 4'h0, 0, OKAY));
        vecs.push_back(mkr(BASE + 32'h23, 32'hFF22_FF44, 0, OKAY));
        vecs.push_back(mkw(BASE + 32'h21, 32'h0000_0000, 4'b1000, 0, OKAY));
        vecs.push_back(mkr(BASE + 32'h20, 32'h0022_FF44, 0, OKAY));

        idle_inputs();
        rst_n = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = BASE;
        tick();
        tick();
        check("reset_awready", 32'(bus.awready), 32'd0);
        check("reset_wready", 32'(bus.wready), 32'd0);
        check("reset_arready", 32'(bus.arready), 32'd0);
        check("reset_valids", {30'b0, bus.bvalid, bus.rvalid}, 32'd0);
        check("reset_resps", {28'b0, bus.bresp, bus.rresp}, 32'd0);
        check("reset_rdata", bus.rdata, 32'h0);
        bus.arvalid = 1'b0;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, vecs[i].hold,
                         vecs[i].exp_resp, $sformatf("vec%0d_wr", i));
            else
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].hold, vecs[i].exp_resp,
                        $sformatf("vec%0d_rd", i));
        end

        do_write(BASE + 32'h30, 32'h0102_0304, 4'hF, 3, 0, 0, OKAY, "w_first");
        do_write(BASE + 32'h34, 32'h0A0B_0C0D, 4'hF, 0, 3, 0, OKAY, "aw_first");
        do_read(BASE + 32'h30, 32'h0102_0304, 0, OKAY, "w_first_rb");
        do_read(BASE + 32'h34, 32'h0A0B_0C0D, 0, OKAY, "aw_first_rb");

        test_round_robin();
        test_reset_mid_read();

        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            do_write(BASE + 32'(4 * i), v, 4'hF, 0, 0, 0, OKAY, $sformatf("preload%0d", i));
            model[i] = v;
        end
        run_random(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
